// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle: hazard sources in, stage enables/flushes out.
// stall_cnt exists only when HAZARD_PERF_CNT_EN is defined.
interface hazard_unit_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  ex_rt;
  logic        ex_memRd;
  logic        ex_branch_taken;
  logic        ihit;
  logic        dmem_req;
  logic        dhit;
  logic        halt_in;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_flush;
  logic        halted;
  logic        dmem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, ex_rt, ex_memRd, ex_branch_taken, ihit, dmem_req, dhit, halt_in,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, memwb_flush, halted, dmem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, ex_memRd, ex_branch_taken, ihit, dmem_req, dhit, halt_in,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, memwb_flush, halted, dmem_timeout, stall_cnt
  );
`else
  modport master (
    output id_rs, id_rt, ex_rt, ex_memRd, ex_branch_taken, ihit, dmem_req, dhit, halt_in,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, memwb_flush, halted, dmem_timeout
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, ex_memRd, ex_branch_taken, ihit, dmem_req, dhit, halt_in,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, memwb_flush, halted, dmem_timeout
  );
`endif
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush control, data-memory wait watchdog and sticky halt.
// Optional stall cycle counter enabled by defining HAZARD_PERF_CNT_EN.
//
// state  | meaning
// RUN    | normal issue; halt/data-wait/branch/load-use/ifetch resolved by priority
// DWAIT  | pipeline frozen until data memory completes the MEM access
// HALTED | everything disabled until reset
module hazard_unit (
  input  logic         CLK,
  input  logic         nRST,
  hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush;
  logic load_use, data_wait;

  assign load_use  = hz.ex_memRd && (hz.ex_rt != 5'd0) &&
                     ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));
  assign data_wait = hz.dmem_req && !hz.dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = 8'd0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.halt_in) begin
          state_d = HALTED;
        end else if (data_wait) begin
          // Freeze the front of the pipe and push a bubble into MEM/WB;
          // this cycle already counts as the first wait cycle.
          memwb_en    = 1'b1;
          memwb_flush = 1'b1;
          wait_cnt_d  = 8'd1;
          state_d     = DWAIT;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (hz.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (!hz.ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end

      DWAIT: begin
        if (hz.dhit) begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          state_d  = RUN;
        end else begin
          memwb_en    = 1'b1;
          memwb_flush = 1'b1;
          wait_cnt_d  = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Outputs are combinational, so reset must also silence them directly.
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  assign timeout_d = timeout_q || (wait_cnt_d == 8'hFF);

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.idex_en      = idex_en;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_en     = memwb_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.memwb_flush  = memwb_flush;
  assign hz.halted       = (state_q == HALTED);
  assign hz.dmem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALTED) && !pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed scenarios then random traffic,
// expected outputs from a cycle-level behavioural model, checked by a separate monitor.
module tb_hazard_unit;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  hazard_unit_if hz ();

  hazard_unit dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (hz.slave)
  );

  typedef struct packed {
    logic [7:0]  ctl;   // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}
    logic        halted;
    logic        timeout;
    logic [15:0] stall;
  } exp_t;

  localparam logic [7:0] C_NONE   = 8'b00000_000;
  localparam logic [7:0] C_ALL    = 8'b11111_000;
  localparam logic [7:0] C_FREEZE = 8'b00001_001;
  localparam logic [7:0] C_BRANCH = 8'b11111_110;
  localparam logic [7:0] C_LDUSE  = 8'b00111_010;
  localparam logic [7:0] C_IMISS  = 8'b01111_100;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Model state: what the pipeline "is doing" rather than how the RTL encodes it.
  bit m_halted  = 1'b0;
  bit m_waiting = 1'b0;
  bit m_timeout = 1'b0;
  int m_run     = 0;   // consecutive cycles stuck on data memory
  int m_stall   = 0;

  initial begin
    hz.id_rs = '0; hz.id_rt = '0; hz.ex_rt = '0;
    hz.ex_memRd = 1'b0; hz.ex_branch_taken = 1'b0; hz.ihit = 1'b1;
    hz.dmem_req = 1'b0; hz.dhit = 1'b0; hz.halt_in = 1'b0;
  end

  task automatic drive(input bit rst, input bit [4:0] rs, input bit [4:0] rt,
                       input bit [4:0] ert, input bit memrd, input bit br,
                       input bit ih, input bit dreq, input bit dh, input bit hlt);
    exp_t       e;
    logic [7:0] c;
    bit         lu;
    bit         was_halted;
    @(posedge CLK);
    #1;
    nRST = rst;
    hz.id_rs = rs; hz.id_rt = rt; hz.ex_rt = ert;
    hz.ex_memRd = memrd; hz.ex_branch_taken = br; hz.ihit = ih;
    hz.dmem_req = dreq; hz.dhit = dh; hz.halt_in = hlt;

    if (!rst) begin
      m_halted = 1'b0; m_waiting = 1'b0; m_timeout = 1'b0;
      m_run = 0; m_stall = 0;
    end
    e.halted  = m_halted;
    e.timeout = m_timeout;
    e.stall   = 16'(m_stall);
    was_halted = m_halted;
    lu = memrd && (ert != 5'd0) && ((ert == rs) || (ert == rt));

    if (!rst) begin
      c = C_NONE;
    end else if (m_halted) begin
      c = C_NONE;
    end else if (m_waiting) begin
      if (dh) begin
        c = C_ALL; m_waiting = 1'b0; m_run = 0;
      end else begin
        c = C_FREEZE; m_run = (m_run < 255) ? m_run + 1 : 255;
      end
    end else if (hlt) begin
      c = C_NONE; m_halted = 1'b1; m_run = 0;
    end else if (dreq && !dh) begin
      c = C_FREEZE; m_waiting = 1'b1; m_run = 1;
    end else begin
      m_run = 0;
      if (br)       c = C_BRANCH;
      else if (lu)  c = C_LDUSE;
      else if (!ih) c = C_IMISS;
      else          c = C_ALL;
    end

    if (rst) begin
      if (m_run >= 255) m_timeout = 1'b1;
      if (!was_halted && !c[7] && m_stall < 65535) m_stall++;
    end
    e.ctl = c;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Monitor: samples combinational outputs mid-cycle and scores against the queue.
  initial begin
    exp_t        e;
    logic [9:0]  act, req;
    int          cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
               hz.ifid_flush, hz.idex_flush, hz.memwb_flush, hz.halted, hz.dmem_timeout};
        req = {e.ctl, e.halted, e.timeout};
        n_cmp++;
        if (act !== req) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d actual=%b required=%b (pc,ifid,idex,exmem,memwb,ifl,xfl,mfl,halt,tmo)",
                   cyc, act, req);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (hz.stall_cnt !== e.stall) begin
          n_bad++;
          $display("FAIL stall_cnt cyc=%0d actual=%0d required=%0d", cyc, hz.stall_cnt, e.stall);
        end
`endif
      end else if (done) begin
        break;
      end
      if (cyc > 20000) begin
        n_bad++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        break;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    // reset state
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 5, 5, 5, 1, 1, 0, 1, 0, 1);
    idle(2);

    // load-use: one bubble, then bubble sits in EX
    drive(1, 5, 0, 5, 1, 0, 1, 0, 0, 0);
    drive(1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);   // load to r0 is never a hazard

    // 4 ifetch misses + 1 load-use from a clean reset
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 7, 7, 1, 0, 1, 0, 0, 0);
    idle(2);

    // data wait: 3 frozen cycles, release on dhit
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);   // coincident hit: no wait

    // branch wins over load-use
    drive(1, 9, 0, 9, 1, 1, 1, 0, 0, 0);
    idle(1);

    // reset abandons DWAIT
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);

    // watchdog
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    idle(3);

    // halt, toggles ignored, reset pulse recovers
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      drive(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 99) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 299) == 0));

    @(posedge CLK);
    done = 1'b1;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: CLK and nRST.
REQ-002 SHALL expose these ports (name, direction, width, meaning):
- CLK  in  1  pipeline clock, rising edge
- nRST  in  1  async active-low reset
- id_rs, id_rt  in  5 each  source regs of instruction in ID
- ex_rt  in  5  dest reg of instruction in EX
- ex_memRd  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved taken branch/jump
- ihit  in  1  instruction memory returned data this cycle
- dmem_req  in  1  MEM stage has a load/store outstanding
- dhit  in  1  data memory completed MEM access this cycle
- halt_in  in  1  halt instruction reached MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble into stage register
- halted  out  1  sticky halt
- dmem_timeout  out  1  sticky data-memory watchdog flag
- stall_cnt  out  16  stall cycle counter (present only per REQ-020)

Function
REQ-003 SHALL implement FSM states RUN, DWAIT, HALTED; outputs are combinational from state and inputs.
REQ-004 SHALL, in RUN, apply priority halt_in > data wait > branch flush > load-use > instruction wait.
REQ-005 SHALL, in RUN with halt_in=1, drive all enables 0 and go to HALTED next edge.
REQ-006 SHALL, in RUN with dmem_req=1 and dhit=0, drive pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, and go to DWAIT.
REQ-007 SHALL, in RUN with ex_branch_taken=1, drive pc_en=1, ifid_flush=1, idex_flush=1, remaining enables 1; single cycle, no state change.
REQ-008 SHALL detect load-use as ex_memRd=1, ex_rt!=0, and ex_rt equal to id_rs or id_rt; drive pc_en=0, ifid_en=0, idex_flush=1, remaining enables 1; exactly one bubble per hazard.
REQ-009 SHALL, in RUN with ihit=0 and no higher-priority condition, drive pc_en=0 and ifid_flush=1, remaining enables 1.
REQ-010 SHALL, in RUN with no condition, drive all enables 1 and all flushes 0.
REQ-011 SHALL, in DWAIT, hold the REQ-006 freeze while dhit=0; when dhit=1, drive all enables 1 and memwb_flush=0 in that cycle and return to RUN.
REQ-012 SHALL count consecutive DWAIT cycles in an 8-bit wait counter, saturating at 255, cleared on entering RUN.
REQ-013 SHALL set dmem_timeout when the wait counter reaches 255; it SHALL remain set until reset.
REQ-014 SHALL, in HALTED, drive all enables 0, all flushes 0, halted=1, and ignore all inputs until reset.
REQ-015 SHALL resolve dhit=1 coincident with dmem_req=1 in RUN as no wait (no DWAIT entry).
REQ-016 SHALL treat a branch flush coincident with a load-use hazard as the branch flush only.

Reset
REQ-017 SHALL, while nRST=0, force state RUN, wait counter 0, halted=0, dmem_timeout=0, stall_cnt=0, all enables 0, all flushes 0.
REQ-018 SHALL, on nRST assertion mid-DWAIT or in HALTED, abandon the state immediately with no pending flush.
REQ-019 SHALL, on the first edge after nRST deasserts, evaluate RUN rules normally.

Configuration
REQ-020 SHALL, with HAZARD_PERF_CNT_EN defined, provide stall_cnt: +1 on every cycle with pc_en=0 outside HALTED, saturating at 16'hFFFF; without the macro, the stall_cnt port and logic SHALL be absent, with all other behaviour identical.

Verification
REQ-021 Load-use: ex_memRd=1, ex_rt=5, id_rs=5, ihit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle (bubble in EX) all enables 1.
REQ-022 Data wait: dmem_req=1, dhit=0 for 3 cycles then dhit=1 -> 3 freeze cycles with memwb_flush=1, release on the dhit cycle, state RUN.
REQ-023 Watchdog: dmem_req=1, dhit=0 for 300 cycles -> dmem_timeout=1 from cycle 255 onward, still 1 after dhit=1.
REQ-024 Branch vs load-use: ex_branch_taken=1 with load-use match -> pc_en=1, ifid_flush=1, idex_flush=1.
REQ-025 Halt then reset: halt_in=1 -> halted=1, enables 0 despite input toggles; nRST pulse low -> halted=0, RUN.
REQ-026 HAZARD_PERF_CNT_EN: 4 ihit=0 cycles plus 1 load-use -> stall_cnt=5; compile without the macro -> port absent, REQ-021 to REQ-025 pass.
